// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit packed-BCD adder/subtractor, one digit per clock,
// least significant digit first, with a start/busy/done handshake.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request a new operation (sampled only while idle)
//   sub             0 = add, 1 = subtract (A - B - cin)
//   Augend, Addend  packed BCD operands, digit 0 in bits [3:0]
//   cin             carry-in (add) / borrow-in (sub)
//   busy            high while an operation is in progress
//   done            one-cycle pulse when sum/outcarry/invalid update
//   sum             packed BCD result, held between operations
//   outcarry        add: decimal carry out; sub: 1 = no borrow
//   invalid         a latched operand digit was greater than 9
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   Augend,
  input  logic [4*DIGITS-1:0]   Addend,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  outcarry,
  output logic                  invalid
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_sub;
  logic            r_carry;
  logic            r_inv_pend;
  logic [CW-1:0]   r_cnt;

  logic            w_inv_in;
  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_raw;
  logic [3:0]      w_b_dig;
  logic [4:0]      w_s;
  logic            w_carry;
  logic [3:0]      w_digit;
  logic [W-1:0]    w_res_next;

  // Flag any non-decimal digit in either incoming operand
  always_comb begin
    w_inv_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((Augend[4*i +: 4] > 4'd9) || (Addend[4*i +: 4] > 4'd9)) begin
        w_inv_in = 1'b1;
      end
    end
  end

  // One decimal digit step; subtraction uses the nine's complement of B
  // with the inverted borrow as initial carry, so A - B - cin falls out as
  // a plain decimal add.
  always_comb begin
    w_a_dig = r_a[32'(r_cnt)*4 +: 4];
    w_b_raw = r_b[32'(r_cnt)*4 +: 4];
    w_b_dig = r_sub ? 4'(4'd9 - w_b_raw) : w_b_raw;
    w_s     = 5'(w_a_dig) + 5'(w_b_dig) + 5'(r_carry);
    w_carry = (w_s > 5'd9);
    w_digit = w_carry ? 4'(w_s + 5'd6) : w_s[3:0];
  end

  // Partial result with the current digit dropped into its slot
  always_comb begin
    w_res_next = r_res;
    w_res_next[32'(r_cnt)*4 +: 4] = w_digit;
  end

  // Control FSM and datapath registers; outputs only change on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_inv_pend <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      outcarry   <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a        <= Augend;
            r_b        <= Addend;
            r_sub      <= sub;
            r_carry    <= sub ? ~cin : cin;
            r_res      <= '0;
            r_cnt      <= '0;
            r_inv_pend <= w_inv_in;
            busy       <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_carry;
          if (r_cnt == LAST) begin
            sum      <= w_res_next;
            outcarry <= w_carry;
            invalid  <= r_inv_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_cnt    <= '0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder: directed vector tables for DIGITS=4 and
// DIGITS=1, handshake/reset sequences, and random operations checked against
// an integer-arithmetic reference model.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, oc4, inv4;
  logic [15:0] sum4;

  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, oc1, inv1;
  logic [3:0]  sum1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
    .Augend(a4), .Addend(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .outcarry(oc4), .invalid(inv4)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
    .Augend(a1), .Addend(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .outcarry(oc1), .invalid(inv1)
  );

  typedef struct {
    bit          sub;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] es;
    bit          eoc;
    bit          einv;
  } vec_t;

  vec_t v4[9];
  vec_t v1[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [15:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input longint x, input int d);
    logic [15:0] v = '0;
    longint t = x;
    for (int i = 0; i < d; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  // Reference: decimal arithmetic on integers, modulo 10^d
  task automatic model(input bit s, input logic [15:0] a, input logic [15:0] b, input bit c,
                       input int d, output logic [15:0] rs, output bit roc);
    longint av, bv, p, r;
    av = bcd2int(a, d);
    bv = bcd2int(b, d);
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (!s) begin
      r = av + bv + longint'(c);
      roc = (r >= p);
      if (roc) r = r - p;
    end else begin
      r = av - bv - longint'(c);
      roc = (r >= 0);
      if (!roc) r = r + p;
    end
    rs = int2bcd(r, d);
  endtask

  function automatic logic [15:0] rand_bcd(input int d);
    logic [15:0] v = '0;
    for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Issue one start pulse and wait (bounded) for done; lat = negedges until done, 0 on timeout
  task automatic run_op(input bit use1, input bit s, input logic [15:0] a, input logic [15:0] b,
                        input bit c, output logic [15:0] rs, output bit roc, output bit rinv,
                        output bit rbusy, output int lat);
    @(negedge clk);
    if (use1) begin
      sub1 = s; a1 = a[3:0]; b1 = b[3:0]; cin1 = c; start1 = 1'b1;
    end else begin
      sub4 = s; a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    end
    lat = 0; rs = '0; roc = 1'b0; rinv = 1'b0; rbusy = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      if (use1 ? done1 : done4) begin
        lat = n;
        rs    = use1 ? {12'h000, sum1} : sum4;
        roc   = use1 ? oc1 : oc4;
        rinv  = use1 ? inv1 : inv4;
        rbusy = use1 ? busy1 : busy4;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] rs, es, hold;
    bit roc, rinv, rbusy, eoc;
    int lat, ndone, idx, last;
    logic [15:0] qa[4], qb[4], qs[4];
    bit qsub[4], qcin[4], qoc[4];

    v4[0] = '{1'b0, 16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0};
    v4[1] = '{1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    v4[2] = '{1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0};
    v4[3] = '{1'b1, 16'h1234, 16'h5000, 1'b0, 16'h6234, 1'b0, 1'b0};
    v4[4] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0};
    v4[5] = '{1'b0, 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    v4[6] = '{1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    v4[7] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b0, 1'b0};
    v4[8] = '{1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};

    v1[0] = '{1'b0, 16'h0003, 16'h0006, 1'b1, 16'h0000, 1'b1, 1'b0};
    v1[1] = '{1'b0, 16'h0009, 16'h0009, 1'b1, 16'h0009, 1'b1, 1'b0};
    v1[2] = '{1'b0, 16'h0002, 16'h0005, 1'b1, 16'h0008, 1'b0, 1'b0};
    v1[3] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0009, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("reset busy", 64'(busy4), 64'd0);
    chk("reset done", 64'(done4), 64'd0);
    chk("reset sum", 64'(sum4), 64'd0);
    chk("reset outcarry", 64'(oc4), 64'd0);
    chk("reset invalid", 64'(inv4), 64'd0);
    chk("reset sum d1", 64'(sum1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed tables
    foreach (v4[i]) begin
      run_op(1'b0, v4[i].sub, v4[i].a, v4[i].b, v4[i].cin, rs, roc, rinv, rbusy, lat);
      chk($sformatf("vec4[%0d] sum", i), 64'(rs), 64'(v4[i].es));
      chk($sformatf("vec4[%0d] outcarry", i), 64'(roc), 64'(v4[i].eoc));
      chk($sformatf("vec4[%0d] invalid", i), 64'(rinv), 64'(v4[i].einv));
      chk($sformatf("vec4[%0d] latency", i), 64'(lat), 64'd5);
      chk($sformatf("vec4[%0d] busy at done", i), 64'(rbusy), 64'd0);
    end
    foreach (v1[i]) begin
      run_op(1'b1, v1[i].sub, v1[i].a, v1[i].b, v1[i].cin, rs, roc, rinv, rbusy, lat);
      chk($sformatf("vec1[%0d] sum", i), 64'(rs), 64'(v1[i].es));
      chk($sformatf("vec1[%0d] outcarry", i), 64'(roc), 64'(v1[i].eoc));
      chk($sformatf("vec1[%0d] latency", i), 64'(lat), 64'd2);
    end

    // Start while busy is ignored; sum holds until the single done
    hold = sum4;
    @(negedge clk);
    sub4 = 1'b0; a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("ignore busy high", 64'(busy4), 64'd1);
    @(negedge clk);
    a4 = 16'h4444; b4 = 16'h4444; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      if (done4) begin
        ndone++;
        chk("ignore result", 64'(sum4), 64'h3333);
      end else if (ndone == 0) begin
        chk("ignore hold", 64'(sum4), 64'(hold));
      end
      @(negedge clk);
    end
    chk("ignore done count", 64'(ndone), 64'd1);

    // Back-to-back with start held high; new operands applied on each done cycle
    for (int i = 0; i < 4; i++) begin
      qa[i] = rand_bcd(4); qb[i] = rand_bcd(4);
      qsub[i] = 1'($urandom_range(0, 1)); qcin[i] = 1'($urandom_range(0, 1));
      model(qsub[i], qa[i], qb[i], qcin[i], 4, qs[i], qoc[i]);
    end
    hold = sum4;
    @(negedge clk);
    sub4 = qsub[0]; a4 = qa[0]; b4 = qb[0]; cin4 = qcin[0]; start4 = 1'b1;
    idx = 0; last = 0;
    for (int n = 1; n <= 40 && idx < 4; n++) begin
      @(negedge clk);
      if (done4) begin
        chk($sformatf("b2b[%0d] sum", idx), 64'(sum4), 64'(qs[idx]));
        chk($sformatf("b2b[%0d] outcarry", idx), 64'(oc4), 64'(qoc[idx]));
        chk($sformatf("b2b[%0d] spacing", idx), 64'(n - last), 64'd5);
        last = n;
        hold = sum4;
        idx++;
        if (idx < 4) begin
          sub4 = qsub[idx]; a4 = qa[idx]; b4 = qb[idx]; cin4 = qcin[idx];
        end else begin
          start4 = 1'b0;
        end
      end else begin
        chk("b2b hold", 64'(sum4), 64'(hold));
      end
    end
    start4 = 1'b0;
    chk("b2b completed", 64'(idx), 64'd4);

    // Reset during RUN aborts without done
    run_op(1'b0, 1'b0, 16'h1234, 16'h1111, 1'b0, rs, roc, rinv, rbusy, lat);
    chk("pre-reset sum", 64'(rs), 64'h2345);
    @(negedge clk);
    sub4 = 1'b0; a4 = 16'h5555; b4 = 16'h4444; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy4), 64'd0);
    chk("abort sum", 64'(sum4), 64'd0);
    chk("abort outcarry", 64'(oc4), 64'd0);
    chk("abort invalid", 64'(inv4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    chk("abort busy after", 64'(busy4), 64'd0);
    run_op(1'b0, 1'b0, 16'h5555, 16'h4444, 1'b1, rs, roc, rinv, rbusy, lat);
    chk("post-reset sum", 64'(rs), 64'h0000);
    chk("post-reset outcarry", 64'(roc), 64'd1);
    chk("post-reset latency", 64'(lat), 64'd5);

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      bit rsub, rcin;
      ra = rand_bcd(4); rb = rand_bcd(4);
      rsub = 1'($urandom_range(0, 1)); rcin = 1'($urandom_range(0, 1));
      model(rsub, ra, rb, rcin, 4, es, eoc);
      run_op(1'b0, rsub, ra, rb, rcin, rs, roc, rinv, rbusy, lat);
      chk($sformatf("rand4[%0d] sum", i), 64'(rs), 64'(es));
      chk($sformatf("rand4[%0d] outcarry", i), 64'(roc), 64'(eoc));
      chk($sformatf("rand4[%0d] invalid", i), 64'(rinv), 64'd0);
      chk($sformatf("rand4[%0d] latency", i), 64'(lat), 64'd5);
    end
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      bit rsub, rcin;
      ra = rand_bcd(1); rb = rand_bcd(1);
      rsub = 1'($urandom_range(0, 1)); rcin = 1'($urandom_range(0, 1));
      model(rsub, ra, rb, rcin, 1, es, eoc);
      run_op(1'b1, rsub, ra, rb, rcin, rs, roc, rinv, rbusy, lat);
      chk($sformatf("rand1[%0d] sum", i), 64'(rs), 64'(es));
      chk($sformatf("rand1[%0d] outcarry", i), 64'(roc), 64'(eoc));
      chk($sformatf("rand1[%0d] latency", i), 64'(lat), 64'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
